// File: rtl/sram_responder.sv
// Single-port word SRAM serving the processor sram_* port, with a host loader
// port (auto-incrementing pointer), access counters and a sticky out-of-range flag.
module sram_responder #(
  parameter int DEPTH = 65536,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] sram_ADDR,
  input  logic [31:0]   sram_DI,
  input  logic          sram_EN,
  input  logic          sram_WE,
  output logic [31:0]   sram_DO,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [31:0]   host_wdata,
  input  logic          host_ptr_ld,
  input  logic [AW-1:0] host_ptr_val,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [31:0]   host_rdata,
  output logic [AW-1:0] host_ptr,
  input  logic          stat_clr,
  output logic [31:0]   cpu_wr_cnt,
  output logic [31:0]   host_acc_cnt,
  output logic          oob_err
);

  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]   DEPTH_U  = 32'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [31:0]   CNT_MAX  = 32'hFFFF_FFFF;

  logic [31:0]   mem [DEPTH];
  logic          cpu_in_range;
  logic          cpu_wr;
  logic [IW-1:0] cpu_idx;
  logic [IW-1:0] host_idx;
  logic [AW-1:0] ptr_ld_mod;
  logic [AW-1:0] ptr_inc;

  // The processor always wins; the host only gets idle cycles.
  assign host_gnt     = host_req & ~sram_EN;
  assign cpu_in_range = (32'(sram_ADDR) < DEPTH_U);
  assign cpu_wr       = sram_EN & sram_WE;
  assign cpu_idx      = sram_ADDR[IW-1:0];
  assign host_idx     = host_ptr[IW-1:0];
  assign ptr_ld_mod   = AW'(32'(host_ptr_val) % DEPTH_U);
  assign ptr_inc      = (host_ptr == PTR_LAST) ? '0 : host_ptr + AW'(1);

  // Array is never cleared, but no write may land while reset is held low.
  always_ff @(posedge clk or negedge reset) begin
    if (reset) begin
      if (cpu_wr && cpu_in_range) mem[cpu_idx] <= sram_DI;
      else if (host_gnt && host_we) mem[host_idx] <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_DO      <= '0;
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
      host_ptr     <= '0;
      cpu_wr_cnt   <= '0;
      host_acc_cnt <= '0;
      oob_err      <= 1'b0;
    end else begin
      if (sram_EN) sram_DO <= cpu_in_range ? mem[cpu_idx] : 32'h0;

      host_rvalid <= host_gnt & ~host_we;
      if (host_gnt && !host_we) host_rdata <= mem[host_idx];

      // A load replaces the increment; a simultaneous access still used the old pointer.
      if (host_ptr_ld) host_ptr <= ptr_ld_mod;
      else if (host_gnt) host_ptr <= ptr_inc;

      if (stat_clr) begin
        cpu_wr_cnt   <= '0;
        host_acc_cnt <= '0;
        oob_err      <= 1'b0;
      end else begin
        if (cpu_wr && cpu_wr_cnt != CNT_MAX) cpu_wr_cnt <= cpu_wr_cnt + 32'd1;
        if (host_gnt && host_acc_cnt != CNT_MAX) host_acc_cnt <= host_acc_cnt + 32'd1;
        if (sram_EN && !cpu_in_range) oob_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (DEPTH=1024) with a queue of expected read data.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI;
  logic        sram_EN;
  logic        sram_WE;
  logic [31:0] sram_DO;
  logic        host_req;
  logic        host_we;
  logic [31:0] host_wdata;
  logic        host_ptr_ld;
  logic [15:0] host_ptr_val;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic [15:0] host_ptr;
  logic        stat_clr;
  logic [31:0] cpu_wr_cnt;
  logic [31:0] host_acc_cnt;
  logic        oob_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];

  sram_responder #(.DEPTH(1024), .AW(16)) dut (
    .clk(clk), .reset(reset),
    .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE),
    .sram_DO(sram_DO),
    .host_req(host_req), .host_we(host_we), .host_wdata(host_wdata),
    .host_ptr_ld(host_ptr_ld), .host_ptr_val(host_ptr_val),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_ptr(host_ptr),
    .stat_clr(stat_clr), .cpu_wr_cnt(cpu_wr_cnt), .host_acc_cnt(host_acc_cnt),
    .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sram_EN = 1'b0; sram_WE = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_ptr_ld = 1'b0; stat_clr = 1'b0;
  endtask

  // One processor cycle; optionally queue and compare the registered read data.
  task automatic apply_stimulus(input logic [15:0] addr, input logic we, input logic [31:0] data,
                                input logic chk, input logic [31:0] exp_do, input string tag);
    @(negedge clk);
    sram_EN = 1'b1; sram_WE = we; sram_ADDR = addr; sram_DI = data;
    if (chk) sb.push_back(exp_do);
    @(posedge clk); #1;
    if (chk) check_output(tag, sram_DO, sb.pop_front());
    idle();
  endtask

  task automatic host_access(input logic we, input logic [31:0] wdata, input logic ld,
                             input logic [15:0] ldval, input logic [31:0] exp_rd, input string tag);
    @(negedge clk);
    host_req = 1'b1; host_we = we; host_wdata = wdata; host_ptr_ld = ld; host_ptr_val = ldval;
    if (!we) sb.push_back(exp_rd);
    #1 check_output({tag, "_gnt"}, 32'(host_gnt), 32'd1);
    @(posedge clk); #1;
    if (!we) begin
      check_output({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
      check_output({tag, "_rdata"}, host_rdata, sb.pop_front());
    end
    idle();
  endtask

  task automatic load_ptr(input logic [15:0] val);
    @(negedge clk);
    host_ptr_ld = 1'b1; host_ptr_val = val;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    reset = 1'b0; sram_ADDR = '0; sram_DI = '0; host_wdata = '0; host_ptr_val = '0;
    idle();
    #1;
    check_output("rst_do", sram_DO, 32'h0);
    check_output("rst_ptr", 32'(host_ptr), 32'h0);
    check_output("rst_rvalid", 32'(host_rvalid), 32'h0);
    check_output("rst_cnt", cpu_wr_cnt | host_acc_cnt, 32'h0);
    check_output("rst_oob", 32'(oob_err), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Processor write then read
    apply_stimulus(16'h0010, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, "wr10");
    apply_stimulus(16'h0010, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "rd10");
    check_output("cpu_wr_cnt1", cpu_wr_cnt, 32'd1);

    // Read-first during write
    apply_stimulus(16'd5, 1'b1, 32'h11111111, 1'b0, 32'h0, "wr5a");
    apply_stimulus(16'd5, 1'b1, 32'h22222222, 1'b1, 32'h11111111, "rdw5");
    apply_stimulus(16'd5, 1'b0, 32'h0, 1'b1, 32'h22222222, "rd5");

    // Host burst load with wrap
    load_ptr(16'd1022);
    check_output("ptr_ld", 32'(host_ptr), 32'd1022);
    for (int i = 0; i < 4; i++) host_access(1'b1, 32'hA0 + 32'(i), 1'b0, 16'h0, 32'h0, "hwr");
    check_output("ptr_wrap", 32'(host_ptr), 32'd2);
    check_output("host_cnt4", host_acc_cnt, 32'd4);
    apply_stimulus(16'd1022, 1'b0, 32'h0, 1'b1, 32'hA0, "rd1022");
    apply_stimulus(16'd1023, 1'b0, 32'h0, 1'b1, 32'hA1, "rd1023");
    apply_stimulus(16'd0, 1'b0, 32'h0, 1'b1, 32'hA2, "rd0");
    apply_stimulus(16'd1, 1'b0, 32'h0, 1'b1, 32'hA3, "rd1");

    // Load coinciding with a granted read: access uses old pointer, load taken mod DEPTH
    apply_stimulus(16'd2, 1'b1, 32'h5555AAAA, 1'b0, 32'h0, "wr2");
    host_access(1'b0, 32'h0, 1'b1, 16'd2000, 32'h5555AAAA, "hrd_ld");
    check_output("ptr_mod", 32'(host_ptr), 32'd976);

    // Arbitration: processor holds the array for three cycles
    load_ptr(16'h0010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sram_EN = 1'b1; sram_WE = 1'b0; sram_ADDR = 16'h0010;
      host_req = 1'b1; host_we = 1'b0;
      sb.push_back(32'hDEADBEEF);
      #1 check_output("arb_gnt0", 32'(host_gnt), 32'd0);
      @(posedge clk); #1;
      check_output("arb_do", sram_DO, sb.pop_front());
      check_output("arb_rvalid0", 32'(host_rvalid), 32'd0);
    end
    idle();
    host_access(1'b0, 32'h0, 1'b0, 16'h0, 32'hDEADBEEF, "arb_hrd");
    @(posedge clk); #1;
    check_output("rvalid_pulse", 32'(host_rvalid), 32'd0);
    check_output("ptr_arb", 32'(host_ptr), 32'd17);
    check_output("host_cnt6", host_acc_cnt, 32'd6);

    // Out of range processor access
    apply_stimulus(16'h0400, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0, "wr_oob");
    apply_stimulus(16'h0400, 1'b0, 32'h0, 1'b1, 32'h0, "rd_oob");
    check_output("oob_set", 32'(oob_err), 32'd1);
    apply_stimulus(16'd0, 1'b0, 32'h0, 1'b1, 32'hA2, "rd0_kept");
    check_output("cpu_wr_cnt5", cpu_wr_cnt, 32'd5);
    @(negedge clk);
    stat_clr = 1'b1; sram_EN = 1'b1; sram_WE = 1'b1; sram_ADDR = 16'h0400; sram_DI = 32'h1;
    @(posedge clk); #1;
    idle();
    check_output("clr_oob", 32'(oob_err), 32'd0);
    check_output("clr_cpu_cnt", cpu_wr_cnt, 32'd0);
    check_output("clr_host_cnt", host_acc_cnt, 32'd0);

    // Asynchronous reset between grant and rvalid cycle
    apply_stimulus(16'h0010, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "rd10_b");
    load_ptr(16'd1022);
    host_access(1'b0, 32'h0, 1'b0, 16'h0, 32'hA0, "hrd_pre_rst");
    reset = 1'b0;
    #1;
    check_output("arst_rvalid", 32'(host_rvalid), 32'd0);
    check_output("arst_ptr", 32'(host_ptr), 32'd0);
    check_output("arst_do", sram_DO, 32'd0);
    check_output("arst_rdata", host_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    apply_stimulus(16'd1022, 1'b0, 32'h0, 1'b1, 32'hA0, "keep1022");
    apply_stimulus(16'h0010, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "keep10");
    apply_stimulus(16'd5, 1'b0, 32'h0, 1'b1, 32'h22222222, "keep5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
